// File: rtl/decode_queue.sv
// RV32I(M) decode stage: DEPTH-entry {instr, pc} FIFO feeding a registered
// decoded-operation slot, with flush, illegal detection and x0 write suppression.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int EN_M  = 1,
    localparam int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic             illegal,
    output logic             we3,
    output logic             is_branch_op,
    output logic             is_load_op,
    output logic             is_store_op,
    output logic             A_rdy,
    output logic [2:0]       rwmm,
    output logic [4:0]       Qj,
    output logic [4:0]       Qk,
    output logic [4:0]       wa3,
    output logic [9:0]       Op,
    output logic [31:0]      Vj,
    output logic [31:0]      Vk,
    output logic [31:0]      A,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic        illegal;
        logic        we3;
        logic        is_branch;
        logic        is_load;
        logic        is_store;
        logic        a_rdy;
        logic [2:0]  rwmm;
        logic [4:0]  qj;
        logic [4:0]  qk;
        logic [4:0]  wa3;
        logic [9:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr, input logic [31:0] pc);
        dec_t        d;
        logic        wr;
        logic        ok;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        f3    = instr[14:12];
        f7    = instr[31:25];
        rd    = instr[11:7];
        rj    = instr[19:15];
        rk    = instr[24:20];
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'b0};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        d       = '0;
        d.op    = {f3, 7'b0};
        d.a_rdy = 1'b1;
        d.wa3   = rd;
        wr      = 1'b0;
        ok      = (instr[1:0] == 2'b11);
        case (instr[6:0])
            7'b0010011: begin d.qj = rj; d.vk = imm_i; wr = 1'b1; end
            7'b0110111: begin d.vk = imm_u; wr = 1'b1; end
            7'b0010111: begin d.vj = pc; d.vk = imm_u; wr = 1'b1; end
            7'b0110011: begin
                d.op = {f3, f7}; d.qj = rj; d.qk = rk; wr = 1'b1;
                // SUB/SRA are the only funct7=0100000 forms; MUL/DIV gated by EN_M
                ok = ok & ((f7 == 7'b0000000) ||
                           (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                           (f7 == 7'b0000001 && EN_M != 0));
            end
            7'b1101111: begin d.a = pc + imm_j; d.is_branch = 1'b1; wr = 1'b1; end
            7'b1100111: begin
                d.qj = rj; d.qk = rj; d.a = imm_i; d.a_rdy = 1'b0;
                d.is_branch = 1'b1; wr = 1'b1;
            end
            7'b1100011: begin d.qj = rj; d.qk = rk; d.a = pc + imm_b; d.is_branch = 1'b1; end
            7'b0000011: begin
                d.qj = rj; d.a = imm_i; d.a_rdy = 1'b0; d.rwmm = f3;
                d.is_load = 1'b1; wr = 1'b1;
            end
            7'b0100011: begin
                d.qj = rj; d.qk = rk; d.a = imm_s; d.a_rdy = 1'b0; d.rwmm = f3;
                d.is_store = 1'b1;
            end
            7'b0001111: d.qj = rj;
            7'b1110011: ;
            default:    ok = 1'b0;
        endcase
        if (!ok) begin
            d         = '0;
            d.illegal = 1'b1;
            d.a_rdy   = 1'b1;
            d.op      = {f3, 7'b0};
            d.wa3     = rd;
        end
        d.we3 = wr & ok & (rd != 5'd0);
        return d;
    endfunction

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    dec_t             slot_p1;
    logic [31:0]      pc_p1;
    logic             vld_p1;

    logic push, pop, fifo_empty, load_head, load_in, fifo_wr;
    dec_t        dec_p0;
    logic [31:0] pc_p0;

    assign in_ready   = (fifo_cnt < CNT_W'(DEPTH));
    assign push       = in_valid & in_ready;
    assign pop        = vld_p1 & out_ready;
    assign fifo_empty = (fifo_cnt == '0);
    assign load_head  = pop & ~fifo_empty;
    // Bypass the FIFO only when it is empty and the slot is free this edge
    assign load_in    = push & (~vld_p1 | (pop & fifo_empty));
    assign fifo_wr    = push & ~load_in;
    assign pc_p0      = load_head ? mem[rd_ptr][31:0] : in_pc;
    assign dec_p0     = load_head ? decode(mem[rd_ptr][63:32], mem[rd_ptr][31:0])
                                  : decode(in_instr, in_pc);

    always_ff @(posedge clk) begin
        if (fifo_wr)
            mem[wr_ptr] <= {in_instr, in_pc};
    end

    // Stage p0 -> p1: decoded operation registered into the output slot
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_cnt      <= '0;
            vld_p1        <= 1'b0;
            pc_p1         <= '0;
            slot_p1       <= '0;
            slot_p1.a_rdy <= 1'b1;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (load_head)
                rd_ptr <= rd_ptr + 1'b1;
            if (fifo_wr && !load_head)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (!fifo_wr && load_head)
                fifo_cnt <= fifo_cnt - 1'b1;
            if (load_head || load_in) begin
                slot_p1 <= dec_p0;
                pc_p1   <= pc_p0;
                vld_p1  <= 1'b1;
            end else if (pop) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_valid    = vld_p1;
    assign out_pc       = pc_p1;
    assign illegal      = slot_p1.illegal;
    assign we3          = slot_p1.we3;
    assign is_branch_op = slot_p1.is_branch;
    assign is_load_op   = slot_p1.is_load;
    assign is_store_op  = slot_p1.is_store;
    assign A_rdy        = slot_p1.a_rdy;
    assign rwmm         = slot_p1.rwmm;
    assign Qj           = slot_p1.qj;
    assign Qk           = slot_p1.qk;
    assign wa3          = slot_p1.wa3;
    assign Op           = slot_p1.op;
    assign Vj           = slot_p1.vj;
    assign Vk           = slot_p1.vk;
    assign A            = slot_p1.a;
    assign count        = fifo_cnt + CNT_W'(vld_p1);

endmodule

// File: tb/tb_decode_queue.sv
// Randomised bench for decode_queue: a queue-of-instructions reference model
// plus directed literal checks; two instances cover EN_M=1 and EN_M=0.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 2);

    typedef struct packed {
        logic        illegal;
        logic        we3;
        logic        br;
        logic        ld;
        logic        st;
        logic        a_rdy;
        logic [2:0]  rwmm;
        logic [4:0]  qj;
        logic [4:0]  qk;
        logic [4:0]  wa3;
        logic [9:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;

    logic in_ready_1, out_valid_1, illegal_1, we3_1, br_1, ld_1, st_1, ardy_1;
    logic [2:0] rwmm_1; logic [4:0] qj_1, qk_1, wa3_1; logic [9:0] op_1;
    logic [31:0] pc_1, vj_1, vk_1, a_1; logic [CNT_W-1:0] cnt_1;
    logic in_ready_0, out_valid_0, illegal_0, we3_0, br_0, ld_0, st_0, ardy_0;
    logic [2:0] rwmm_0; logic [4:0] qj_0, qk_0, wa3_0; logic [9:0] op_0;
    logic [31:0] pc_0, vj_0, vk_0, a_0; logic [CNT_W-1:0] cnt_0;

    exp_t d1, d0;
    assign d1 = {illegal_1, we3_1, br_1, ld_1, st_1, ardy_1, rwmm_1, qj_1, qk_1, wa3_1, op_1, vj_1, vk_1, a_1};
    assign d0 = {illegal_0, we3_0, br_0, ld_0, st_0, ardy_0, rwmm_0, qj_0, qk_0, wa3_0, op_0, vj_0, vk_0, a_0};

    decode_queue #(.DEPTH(DEPTH), .EN_M(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_1),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_1), .out_ready(out_ready),
        .out_pc(pc_1), .illegal(illegal_1), .we3(we3_1), .is_branch_op(br_1),
        .is_load_op(ld_1), .is_store_op(st_1), .A_rdy(ardy_1), .rwmm(rwmm_1),
        .Qj(qj_1), .Qk(qk_1), .wa3(wa3_1), .Op(op_1), .Vj(vj_1), .Vk(vk_1), .A(a_1),
        .count(cnt_1));

    decode_queue #(.DEPTH(DEPTH), .EN_M(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_0),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_0), .out_ready(out_ready),
        .out_pc(pc_0), .illegal(illegal_0), .we3(we3_0), .is_branch_op(br_0),
        .is_load_op(ld_0), .is_store_op(st_0), .A_rdy(ardy_0), .rwmm(rwmm_0),
        .Qj(qj_0), .Qk(qk_0), .wa3(wa3_0), .Op(op_0), .Vj(vj_0), .Vk(vk_0), .A(a_0),
        .count(cnt_0));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the ISA field/immediate rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input bit en_m);
        exp_t e;
        bit legal, wr;
        logic [31:0] ii, is, ib, iu, ij;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        ii = 32'($signed(ins[31:20]));
        is = 32'($signed({ins[31:25], ins[11:7]}));
        ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        iu = {ins[31:12], 12'h000};
        ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        e = '0; e.a_rdy = 1; e.op = {f3, 7'd0}; e.wa3 = ins[11:7];
        legal = 1; wr = 0;
        if (ins[6:0] == 7'h13)      begin e.qj = ins[19:15]; e.vk = ii; wr = 1; end
        else if (ins[6:0] == 7'h37) begin e.vk = iu; wr = 1; end
        else if (ins[6:0] == 7'h17) begin e.vj = pc; e.vk = iu; wr = 1; end
        else if (ins[6:0] == 7'h33) begin
            e.op = {f3, f7}; e.qj = ins[19:15]; e.qk = ins[24:20]; wr = 1;
            legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && en_m);
        end
        else if (ins[6:0] == 7'h6F) begin e.a = pc + ij; e.br = 1; wr = 1; end
        else if (ins[6:0] == 7'h67) begin
            e.qj = ins[19:15]; e.qk = ins[19:15]; e.a = ii; e.a_rdy = 0; e.br = 1; wr = 1;
        end
        else if (ins[6:0] == 7'h63) begin e.qj = ins[19:15]; e.qk = ins[24:20]; e.a = pc + ib; e.br = 1; end
        else if (ins[6:0] == 7'h03) begin
            e.qj = ins[19:15]; e.a = ii; e.a_rdy = 0; e.rwmm = f3; e.ld = 1; wr = 1;
        end
        else if (ins[6:0] == 7'h23) begin
            e.qj = ins[19:15]; e.qk = ins[24:20]; e.a = is; e.a_rdy = 0; e.rwmm = f3; e.st = 1;
        end
        else if (ins[6:0] == 7'h0F) e.qj = ins[19:15];
        else if (ins[6:0] != 7'h73) legal = 0;
        if (ins[1:0] != 2'b11) legal = 0;
        if (!legal) begin
            e = '0; e.illegal = 1; e.a_rdy = 1; e.op = {f3, 7'd0}; e.wa3 = ins[11:7];
        end else begin
            e.we3 = wr && (ins[11:7] != 0);
        end
        return e;
    endfunction

    // Whole-queue model: q[0] is what the slot presents, the rest is the FIFO
    logic [63:0] q[$];
    bit m_push, m_pop;
    always @(posedge clk) begin
        if (reset || flush) begin
            q.delete();
        end else begin
            m_push = in_valid && (q.size() <= DEPTH);
            m_pop  = (q.size() > 0) && out_ready;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back({in_instr, in_pc});
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("flow1", {in_ready_1, out_valid_1, cnt_1},
                {q.size() <= DEPTH, q.size() > 0, CNT_W'(q.size())});
            chk("flow0", {in_ready_0, out_valid_0, cnt_0},
                {q.size() <= DEPTH, q.size() > 0, CNT_W'(q.size())});
            if (q.size() > 0) begin
                chk("dec_m1", d1, model(q[0][63:32], q[0][31:0], 1'b1));
                chk("dec_m0", d0, model(q[0][63:32], q[0][31:0], 1'b0));
                chk("pc1", pc_1, q[0][31:0]);
                chk("pc0", pc_0, q[0][31:0]);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1; in_instr = ins; in_pc = pc;
        cyc();
        in_valid = 0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        logic [6:0] opc;
        r = $urandom;
        case ($urandom_range(0, 12))
            0: opc = 7'h13;  1: opc = 7'h37;  2: opc = 7'h17;  3: opc = 7'h33;
            4: opc = 7'h6F;  5: opc = 7'h67;  6: opc = 7'h63;  7: opc = 7'h03;
            8: opc = 7'h23;  9: opc = 7'h0F; 10: opc = 7'h73;
            11: opc = 7'($urandom);
            default: opc = {5'($urandom), 2'b10};
        endcase
        r[6:0] = opc;
        if (opc == 7'h33)
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    exp_t rexp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        reset = 1; cyc(); reset = 0; cmp_en = 1;
        rexp = '0; rexp.a_rdy = 1;
        chk("rst_dec", d1, rexp);
        chk("rst_flow", {in_ready_1, out_valid_1, cnt_1}, {1'b1, 1'b0, CNT_W'(0)});

        // addi x5,x1,-3
        out_ready = 1;
        push1(32'hFFD08293, 32'h100);
        chk("addi", {out_valid_1, qj_1, vk_1, wa3_1, we3_1, op_1, illegal_1, pc_1},
            {1'b1, 5'd1, 32'hFFFFFFFD, 5'd5, 1'b1, 10'd0, 1'b0, 32'h100});
        cyc();

        // jal, then sw queued behind it while the slot is held
        out_ready = 0;
        push1(32'h008000EF, 32'h200);
        chk("jal", {a_1, br_1, we3_1, ardy_1}, {32'h208, 1'b1, 1'b1, 1'b1});
        push1(32'h0021A223, 32'h204);
        chk("jal_hold", {a_1, pc_1, cnt_1}, {32'h208, 32'h200, CNT_W'(2)});
        out_ready = 1; cyc();
        chk("sw", {qj_1, qk_1, a_1, ardy_1, rwmm_1, st_1, pc_1},
            {5'd3, 5'd2, 32'd4, 1'b0, 3'b010, 1'b1, 32'h204});
        cyc();

        // mul with and without M, then all-ones, then nop via push+pop
        out_ready = 0;
        push1(32'h022081B3, 32'h300);
        chk("mul_m1", {op_1, illegal_1, we3_1}, {10'h001, 1'b0, 1'b1});
        chk("mul_m0", {illegal_0, we3_0}, {1'b1, 1'b0});
        out_ready = 1;
        push1(32'hFFFFFFFF, 32'h304);
        chk("ones", {illegal_1, we3_1, cnt_1}, {1'b1, 1'b0, CNT_W'(1)});
        push1(32'h00000013, 32'h308);
        chk("nop", {we3_1, illegal_1, cnt_1}, {1'b0, 1'b0, CNT_W'(1)});
        cyc();

        // fill to DEPTH+1, then drain in order
        out_ready = 0;
        for (int i = 0; i < DEPTH + 2; i++) push1(32'h00100093 + (i << 20), 32'h400 + 4 * i);
        chk("full", {in_ready_1, cnt_1}, {1'b0, CNT_W'(DEPTH + 1)});
        out_ready = 1;
        for (int i = 0; i < DEPTH + 2; i++) cyc();
        chk("drained", {out_valid_1, cnt_1}, {1'b0, CNT_W'(0)});

        // flush with a concurrent push
        out_ready = 0;
        for (int i = 0; i < 3; i++) push1(32'h00000013, 32'h500 + 4 * i);
        flush = 1; in_valid = 1; in_instr = 32'h00500293; in_pc = 32'h600;
        cyc();
        flush = 0; in_valid = 0;
        chk("flush", {out_valid_1, cnt_1}, {1'b0, CNT_W'(0)});
        cyc();
        chk("flush_drop", {out_valid_1, cnt_1}, {1'b0, CNT_W'(0)});

        // steady-state streaming
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            in_instr = rnd_instr(); in_pc = 32'h700 + 4 * i;
            cyc();
            if (i > 0) chk("stream_cnt", cnt_1, CNT_W'(1));
        end
        in_valid = 0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 59) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            in_instr  = rnd_instr();
            in_pc     = {$urandom} & 32'hFFFF_FFFC;
            cyc();
        end
        reset = 0; flush = 0; in_valid = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
